// File: rtl/keypad_emulator.sv
`default_nettype none
// ============================================================================
// Module   : keypad_emulator
// Brief    : Emulates a pressed 4x4 keypad key by answering decoder row strobes
//            on the column lines; keys are queued and pressed/released in turn.
//            Build option KEYPAD_EMU_FIFO_EN selects a 4-entry FIFO queue
//            instead of a single holding register.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_emulator #(
    parameter int HOLD_CYCLES = 1000,
    parameter int GAP_CYCLES  = 1000,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_in,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic [3:0] row,
    output logic [3:0] column,
    output logic       pressed,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       r_cur_key;
    logic [3:0]       w_cur_key_nxt;
    logic             r_done;
    logic             w_done_nxt;

    logic             w_push;
    logic             w_pop;
    logic             w_q_empty;
    logic [3:0]       w_head;

    assign w_push = key_valid && key_ready;
    assign w_pop  = (r_state == S_IDLE) && !w_q_empty;

`ifdef KEYPAD_EMU_FIFO_EN
    logic [3:0] r_mem [0:3];
    logic [1:0] r_wr_ptr;
    logic [1:0] r_rd_ptr;
    logic [2:0] r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= key_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign key_ready = (r_count < 3'd4);
    assign w_q_empty = (r_count == 3'd0);
    assign w_head    = r_mem[r_rd_ptr];
`else
    logic [3:0] r_hold;
    logic       r_hold_vld;

    // A push refills the register even if its old content is popped this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold     <= 4'd0;
            r_hold_vld <= 1'b0;
        end else if (w_push) begin
            r_hold     <= key_in;
            r_hold_vld <= 1'b1;
        end else if (w_pop) begin
            r_hold_vld <= 1'b0;
        end
    end

    assign key_ready = !r_hold_vld;
    assign w_q_empty = !r_hold_vld;
    assign w_head    = r_hold;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_cur_key <= 4'd0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_cur_key <= w_cur_key_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_cur_key_nxt = r_cur_key;
        w_done_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_q_empty) begin
                    w_cur_key_nxt = w_head;
                    w_cnt_nxt     = c_HOLD_LOAD;
                    w_state_nxt   = S_PRESS;
                end
            end
            S_PRESS: begin
                if (r_cnt == '0) begin
                    w_cnt_nxt   = c_GAP_LOAD;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_GAP;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            S_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Key code -> (row strobe, column pattern); must match the decoder's map.
    logic [3:0] w_key_row;
    logic [3:0] w_key_col;

    always_comb begin
        w_key_row = 4'b1111;
        w_key_col = 4'b1111;
        case (r_cur_key)
            4'h1: begin w_key_row = 4'b1110; w_key_col = 4'b1110; end
            4'h2: begin w_key_row = 4'b1110; w_key_col = 4'b1101; end
            4'h3: begin w_key_row = 4'b1110; w_key_col = 4'b1011; end
            4'hA: begin w_key_row = 4'b1110; w_key_col = 4'b0111; end
            4'h4: begin w_key_row = 4'b1101; w_key_col = 4'b1110; end
            4'h5: begin w_key_row = 4'b1101; w_key_col = 4'b1101; end
            4'h6: begin w_key_row = 4'b1101; w_key_col = 4'b1011; end
            4'hB: begin w_key_row = 4'b1101; w_key_col = 4'b0111; end
            4'h7: begin w_key_row = 4'b1011; w_key_col = 4'b1110; end
            4'h8: begin w_key_row = 4'b1011; w_key_col = 4'b1101; end
            4'h9: begin w_key_row = 4'b1011; w_key_col = 4'b1011; end
            4'hC: begin w_key_row = 4'b1011; w_key_col = 4'b0111; end
            4'hE: begin w_key_row = 4'b0111; w_key_col = 4'b1110; end
            4'h0: begin w_key_row = 4'b0111; w_key_col = 4'b1101; end
            4'hF: begin w_key_row = 4'b0111; w_key_col = 4'b1011; end
            4'hD: begin w_key_row = 4'b0111; w_key_col = 4'b0111; end
            default: begin w_key_row = 4'b1111; w_key_col = 4'b1111; end
        endcase
    end

    // Zero-latency path: the decoder samples column in the cycle it drives row.
    assign column  = ((r_state == S_PRESS) && (row == w_key_row)) ? w_key_col : 4'b1111;
    assign pressed = (r_state == S_PRESS);
    assign busy    = (r_state != S_IDLE) || !w_q_empty;
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_keypad_emulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_emulator
// Brief    : Directed bench for keypad_emulator with HOLD_CYCLES=4, GAP_CYCLES=3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_emulator;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_in;
    logic       key_valid;
    logic       key_ready;
    logic [3:0] row;
    logic [3:0] column;
    logic       pressed;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    keypad_emulator #(
        .HOLD_CYCLES(4),
        .GAP_CYCLES (3),
        .CNT_W      (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_in   (key_in),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .row      (row),
        .column   (column),
        .pressed  (pressed),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Decoder code map, laid out row by row as in the keypad.
    logic [3:0] t_code [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    logic [3:0] t_row  [16] = '{4'hE, 4'hE, 4'hE, 4'hE, 4'hD, 4'hD, 4'hD, 4'hD,
                               4'hB, 4'hB, 4'hB, 4'hB, 4'h7, 4'h7, 4'h7, 4'h7};
    logic [3:0] t_col  [16] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE, 4'hD, 4'hB, 4'h7,
                               4'hE, 4'hD, 4'hB, 4'h7, 4'hE, 4'hD, 4'hB, 4'h7};

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [3:0] c);
        key_in    = c;
        key_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (key_ready) break;
            tick();
        end
        total++;
        if (key_ready !== 1'b1) begin
            bad++;
            $display("FAIL push_timeout: key_ready=%b want 1", key_ready);
        end
        tick();
        key_valid = 1'b0;
    endtask

    // Behaves like a scanning decoder: strobe every row, decode the one answer.
    task automatic scan(output logic [3:0] code, output int hits);
        logic [3:0] rv;
        code = 4'h0;
        hits = 0;
        for (int r = 0; r < 4; r++) begin
            rv  = ~(4'b0001 << r);
            row = rv;
            #1;
            if (column !== 4'hF) begin
                hits++;
                for (int j = 0; j < 16; j++) begin
                    if (t_row[j] == rv && t_col[j] == column) code = t_code[j];
                end
            end
        end
        row = 4'hF;
    endtask

    task automatic wait_pressed(input logic lvl, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (pressed === lvl) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_idle;
        for (int i = 0; i < 60; i++) begin
            if (busy === 1'b0) break;
            tick();
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_timeout: busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset;
        int seen;
        rst = 1'b1; key_valid = 1'b0; key_in = 4'h0; row = 4'hF;
        tick();
        total += 5;
        if (column !== 4'hF)    begin bad++; $display("FAIL rst_column: got %h want f", column); end
        if (pressed !== 1'b0)   begin bad++; $display("FAIL rst_pressed: got %b want 0", pressed); end
        if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (key_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", key_ready); end
        if (done !== 1'b0)      begin bad++; $display("FAIL rst_done: got %b want 0", done); end
        tick();
        rst = 1'b0;
        tick();
        // Reset in the middle of PRESS of 0101 with 0011 waiting in the queue.
        push(4'h5);
        push(4'h3);
        row = 4'hD;
        #1;
        total += 2;
        if (pressed !== 1'b1)  begin bad++; $display("FAIL midpress_pressed: got %b want 1", pressed); end
        if (column !== 4'hD)   begin bad++; $display("FAIL midpress_column: got %h want d", column); end
        rst = 1'b1;
        tick();
        total += 4;
        if (column !== 4'hF)    begin bad++; $display("FAIL abort_column: got %h want f", column); end
        if (pressed !== 1'b0)   begin bad++; $display("FAIL abort_pressed: got %b want 0", pressed); end
        if (busy !== 1'b0)      begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        if (key_ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b want 1", key_ready); end
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done !== 1'b0 || pressed !== 1'b0 || busy !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL abort_quiet: active cycles=%0d want 0", seen); end
        row = 4'hF;
    endtask

    task automatic test_single_key;
        logic [3:0] rv;
        logic [3:0] want;
        push(4'h6);
        total += 2;
        if (pressed !== 1'b0) begin bad++; $display("FAIL single_accept_pressed: got %b want 0", pressed); end
        if (busy !== 1'b1)    begin bad++; $display("FAIL single_accept_busy: got %b want 1", busy); end
        for (int k = 0; k < 8; k++) begin
            tick();
            total += 3;
            if (pressed !== (k < 4)) begin bad++; $display("FAIL single_pressed k=%0d: got %b want %b", k, pressed, (k < 4)); end
            if (done !== (k == 4))   begin bad++; $display("FAIL single_done k=%0d: got %b want %b", k, done, (k == 4)); end
            if (busy !== (k < 7))    begin bad++; $display("FAIL single_busy k=%0d: got %b want %b", k, busy, (k < 7)); end
            for (int r = 0; r < 4; r++) begin
                rv   = ~(4'b0001 << r);
                row  = rv;
                #1;
                want = (k < 4 && rv == 4'hD) ? 4'hB : 4'hF;
                total++;
                if (column !== want) begin
                    bad++;
                    $display("FAIL single_column k=%0d row=%h: got %h want %h", k, rv, column, want);
                end
            end
            row = 4'hF;
        end
    endtask

    task automatic test_code_map;
        logic [3:0] code;
        int         hits;
        bit         ok;
        for (int i = 0; i < 16; i++) begin
            push(4'(i));
            wait_pressed(1'b1, ok);
            total++;
            if (!ok) begin bad++; $display("FAIL map_press_timeout code=%h: pressed=%b want 1", 4'(i), pressed); end
            scan(code, hits);
            total++;
            if (hits != 1 || code !== 4'(i)) begin
                bad++;
                $display("FAIL map_decode: got code=%h hits=%0d want code=%h hits=1", code, hits, 4'(i));
            end
            wait_pressed(1'b0, ok);
        end
        wait_idle();
    endtask

    task automatic test_illegal_rows;
        logic [3:0] rows [4] = '{4'h3, 4'hF, 4'h0, 4'h7};
        logic [3:0] want [4] = '{4'hF, 4'hF, 4'hF, 4'hD};
        bit         ok;
        push(4'h0);
        wait_pressed(1'b1, ok);
        for (int i = 0; i < 4; i++) begin
            row = rows[i];
            #1;
            total++;
            if (column !== want[i]) begin
                bad++;
                $display("FAIL illegal_row row=%h: got %h want %h", rows[i], column, want[i]);
            end
        end
        row = 4'hF;
        wait_idle();
    endtask

`ifdef KEYPAD_EMU_FIFO_EN
    task automatic test_back_to_back;
        logic [3:0] keys [5] = '{4'h1, 4'hF, 4'hA, 4'hD, 4'h4};
        int         done_at [8];
        logic [3:0] codes [8];
        int         n_done;
        int         n_press;
        int         hits;
        logic       prev;
        logic [3:0] code;
        for (int i = 0; i < 5; i++) begin
            key_in    = keys[i];
            key_valid = 1'b1;
            total++;
            if (key_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready push=%0d: got %b want 1", i, key_ready); end
            tick();
            if (i == 2) begin
                scan(code, hits);
                total++;
                if (hits != 1 || code !== 4'h1) begin
                    bad++;
                    $display("FAIL b2b_first_key: got code=%h hits=%0d want 1", code, hits);
                end
            end
        end
        // Queue now full: a sixth key must be refused and never pressed.
        key_in = 4'h7;
        total++;
        if (key_ready !== 1'b0) begin bad++; $display("FAIL b2b_full_ready: got %b want 0", key_ready); end
        tick();
        total++;
        if (key_ready !== 1'b0) begin bad++; $display("FAIL b2b_full_ready2: got %b want 0", key_ready); end
        key_valid = 1'b0;
        n_done  = 0;
        n_press = 0;
        prev    = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (done === 1'b1 && n_done < 8) begin
                done_at[n_done] = c;
                n_done++;
            end
            if (pressed === 1'b1 && !prev && n_press < 8) begin
                scan(code, hits);
                codes[n_press] = code;
                n_press++;
            end
            prev = pressed;
            tick();
        end
        total += 2;
        if (n_done != 5)  begin bad++; $display("FAIL b2b_done_count: got %0d want 5", n_done); end
        if (n_press != 4) begin bad++; $display("FAIL b2b_press_count: got %0d want 4", n_press); end
        for (int i = 1; i < 5; i++) begin
            if (i < n_done) begin
                total++;
                if (done_at[i] - done_at[i-1] != 8) begin
                    bad++;
                    $display("FAIL b2b_spacing %0d: got %0d want 8", i, done_at[i] - done_at[i-1]);
                end
            end
            if (i - 1 < n_press) begin
                total++;
                if (codes[i-1] !== keys[i]) begin
                    bad++;
                    $display("FAIL b2b_order %0d: got %h want %h", i, codes[i-1], keys[i]);
                end
            end
        end
        wait_idle();
    endtask
`else
    task automatic test_single_holding;
        logic [3:0] code;
        int         hits;
        int         extra;
        bit         ok;
        key_in    = 4'h2;
        key_valid = 1'b1;
        total++;
        if (key_ready !== 1'b1) begin bad++; $display("FAIL hold_ready0: got %b want 1", key_ready); end
        tick();
        key_in = 4'h8;
        total++;
        if (key_ready !== 1'b0) begin bad++; $display("FAIL hold_ready_full: got %b want 0", key_ready); end
        tick();
        total += 2;
        if (key_ready !== 1'b1) begin bad++; $display("FAIL hold_ready_popped: got %b want 1", key_ready); end
        if (pressed !== 1'b1)   begin bad++; $display("FAIL hold_first_pressed: got %b want 1", pressed); end
        scan(code, hits);
        total++;
        if (hits != 1 || code !== 4'h2) begin
            bad++;
            $display("FAIL hold_first_key: got code=%h hits=%0d want 2", code, hits);
        end
        tick();
        total++;
        if (key_ready !== 1'b0) begin bad++; $display("FAIL hold_second_taken: got %b want 0", key_ready); end
        key_valid = 1'b0;
        wait_pressed(1'b0, ok);
        wait_pressed(1'b1, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL hold_second_timeout: pressed=%b want 1", pressed); end
        scan(code, hits);
        total++;
        if (hits != 1 || code !== 4'h8) begin
            bad++;
            $display("FAIL hold_second_key: got code=%h hits=%0d want 8", code, hits);
        end
        wait_idle();
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            if (pressed !== 1'b0) extra++;
            tick();
        end
        total++;
        if (extra != 0) begin bad++; $display("FAIL hold_duplicate: pressed cycles=%0d want 0", extra); end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        key_valid = 1'b0;
        key_in    = 4'h0;
        row       = 4'hF;
        @(negedge clk);
        test_reset();
        test_single_key();
        test_code_map();
        test_illegal_rows();
`ifdef KEYPAD_EMU_FIFO_EN
        test_back_to_back();
`else
        test_single_holding();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
